// File: rtl/ahb_pkg.sv
// Shared AHB types and the generic slave's state encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_t;

  // Width of a wait-state count that can hold max_delay (at least one bit).
  function automatic int unsigned delay_width(input int unsigned max_delay);
    return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/ahb_wait_lfsr.sv
// Free-running 16-bit LFSR mapped onto a bounded wait-state count.
module ahb_wait_lfsr
  import ahb_pkg::*;
#(
  parameter int unsigned MIN_DELAY = 1,
  parameter int unsigned MAX_DELAY = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  output logic [delay_width(MAX_DELAY)-1:0]   o_delay
);

  localparam int unsigned DW    = delay_width(MAX_DELAY);
  localparam int unsigned RANGE = MAX_DELAY - MIN_DELAY + 1;

  logic [15:0] r_lfsr;
  logic        w_fb;

  // Fibonacci taps 16,14,13,11.
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Advance the LFSR every cycle outside reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_delay = DW'(MIN_DELAY + (32'(r_lfsr) % RANGE));

endmodule

// File: rtl/ahb_generic_slave.sv
// Generic AHB memory slave with pseudo-random wait-state insertion.
module ahb_generic_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned MEM_AW     = 10,
  parameter int unsigned MIN_DELAY  = 1,
  parameter int unsigned MAX_DELAY  = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam int unsigned DW    = delay_width(MAX_DELAY);
  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam logic [DW-1:0] CNT_ONE = DW'(1);

  slave_state_t      r_state;
  logic [MEM_AW-1:0] r_idx;
  logic [1:0]        r_lane;
  logic              r_write;
  hsize_t            r_size;
  logic [DW-1:0]     r_count;
  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DW-1:0]         w_delay;
  htrans_t               w_trans;
  hsize_t                w_size;
  logic                  w_ready_state;
  logic                  w_accept;
  logic                  w_illegal;
  logic [3:0]            w_be;
  logic                  w_unused;

  assign w_addr   = HADDR[ADDR_WIDTH-1:0];
  assign w_trans  = htrans_t'(HTRANS);
  assign w_size   = hsize_t'(HSIZE);
  assign w_unused = ^{HADDR[31:ADDR_WIDTH], w_addr[ADDR_WIDTH-1:MEM_AW+2], HBURST};

  ahb_wait_lfsr #(
    .MIN_DELAY (MIN_DELAY),
    .MAX_DELAY (MAX_DELAY),
    .LFSR_SEED (LFSR_SEED)
  ) u_wait_lfsr (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .o_delay (w_delay)
  );

  assign w_ready_state = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_accept      = w_ready_state && HSEL && HREADY &&
                         ((w_trans == HTRANS_NONSEQ) || (w_trans == HTRANS_SEQ));

  // Size/alignment legality of the address phase being offered.
  always_comb begin
    w_illegal = 1'b0;
    if (HSIZE > 3'(HSIZE_WORD)) begin
      w_illegal = 1'b1;
    end else if ((w_size == HSIZE_HALF) && w_addr[0]) begin
      w_illegal = 1'b1;
    end else if ((w_size == HSIZE_WORD) && (w_addr[1:0] != 2'b00)) begin
      w_illegal = 1'b1;
    end
  end

  // Transfer sequencing: address capture, wait countdown, error response.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_lane  <= '0;
      r_write <= 1'b0;
      r_size  <= HSIZE_BYTE;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_count <= CNT_ONE) begin
            r_state <= ST_DATA;
          end
          r_count <= r_count - CNT_ONE;
        end
        ST_ERR1: begin
          r_state <= ST_ERR2;
        end
        default: begin
          // IDLE, final data cycle and ERR2 can all take a new address phase.
          if (w_accept) begin
            r_idx   <= w_addr[MEM_AW+1:2];
            r_lane  <= w_addr[1:0];
            r_write <= HWRITE;
            r_size  <= w_size;
            r_count <= w_delay;
            if (w_illegal) begin
              r_state <= ST_ERR1;
            end else if (w_delay == '0) begin
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Little-endian lane enables for the latched transfer.
  always_comb begin
    w_be = '0;
    case (r_size)
      HSIZE_BYTE: w_be = 4'b0001 << r_lane;
      HSIZE_HALF: w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: w_be = 4'b1111;
      default:    w_be = '0;
    endcase
  end

  // Merge write data at the closing edge of a write's final data cycle.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (r_state == ST_DATA) && r_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Asynchronous read so a write closing on the accepting edge is already visible.
  assign HRDATA    = ((r_state == ST_DATA) && !r_write) ? r_mem[r_idx] : '0;
  assign HREADYOUT = (r_state != ST_WAIT) && (r_state != ST_ERR1);
  assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_generic_slave.sv
// Bench for ahb_generic_slave: driver pushes expected responses, a monitor
// tracks data phases on the bus and compares when each one completes.
module tb_ahb_generic_slave;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          min_w;
    int          max_w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic        sel_b;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;

  logic [31:0] rdata_a, rdata_b, hrdata;
  logic        ro_a, ro_b, hready;
  logic [1:0]  resp_a, resp_b, hresp;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   wmin = 1;
  int   wmax = 10;

  bit   dp_active = 1'b0;
  int   waits = 0;
  bit   wait_bad = 1'b0;

  always #5 clk = ~clk;

  ahb_generic_slave u_a (
    .HCLK      (clk),
    .HRESET    (rst),
    .HSEL      (hsel & ~sel_b),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (hburst),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HRDATA    (rdata_a),
    .HREADYOUT (ro_a),
    .HRESP     (resp_a)
  );

  ahb_generic_slave #(
    .MIN_DELAY (3),
    .MAX_DELAY (3)
  ) u_b (
    .HCLK      (clk),
    .HRESET    (rst),
    .HSEL      (hsel & sel_b),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (hburst),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HRDATA    (rdata_b),
    .HREADYOUT (ro_b),
    .HRESP     (resp_b)
  );

  assign hrdata = sel_b ? rdata_b : rdata_a;
  assign hready = sel_b ? ro_b : ro_a;
  assign hresp  = sel_b ? resp_b : resp_a;

  // Monitor: idle-cycle checks, wait counting and completion scoring.
  always @(negedge clk) begin
    if (rst) begin
      dp_active = 1'b0;
    end else begin
      if (dp_active) begin
        if (!hready) begin
          waits++;
          if (exp_q.size() > 0 && (hresp !== exp_q[0].resp || hrdata !== 32'h0))
            wait_bad = 1'b1;
        end else begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL unexpected_completion: no expectation queued (rdata=%h resp=%0d)", hrdata, hresp);
          end else begin
            m_e = exp_q.pop_front();
            n_cmp++;
            if (waits < m_e.min_w || waits > m_e.max_w) begin
              n_mis++;
              $display("FAIL %s waits: got %0d, required %0d..%0d", m_e.name, waits, m_e.min_w, m_e.max_w);
            end
            n_cmp++;
            if (wait_bad) begin
              n_mis++;
              $display("FAIL %s wait_outputs: HRESP/HRDATA during wait, required resp=%0d rdata=0", m_e.name, m_e.resp);
            end
            n_cmp++;
            if (hresp !== m_e.resp) begin
              n_mis++;
              $display("FAIL %s resp: got %0d, required %0d", m_e.name, hresp, m_e.resp);
            end
            n_cmp++;
            if (hrdata !== m_e.rdata) begin
              n_mis++;
              $display("FAIL %s rdata: got %h, required %h", m_e.name, hrdata, m_e.rdata);
            end
          end
          dp_active = 1'b0;
        end
      end else begin
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 2'd0 || hrdata !== 32'h0) begin
          n_mis++;
          $display("FAIL idle_outputs: ready=%b resp=%0d rdata=%h, required ready=1 resp=0 rdata=0", hready, hresp, hrdata);
        end
      end
      if (hready && hsel && htrans[1]) begin
        dp_active = 1'b1;
        waits     = 0;
        wait_bad  = 1'b0;
      end
    end
  end

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  endtask

  // Complete the current bus cycle once the selected slave is ready.
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!hready) begin
      n++;
      if (n > 40) begin
        n_cmp++; n_mis++;
        $display("FAIL ready_timeout: HREADY low for %0d cycles, required <= 40", n);
        summary_and_finish();
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // Present an address phase, then supply its write data once accepted.
  task automatic issue(input bit push, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input string nm, input logic [31:0] rd, input logic [1:0] rsp);
    exp_t e;
    if (push) begin
      e.name  = nm;
      e.rdata = rd;
      e.resp  = rsp;
      e.min_w = (rsp == 2'd1) ? 1 : wmin;
      e.max_w = (rsp == 2'd1) ? 1 : wmax;
      exp_q.push_back(e);
    end
    htrans = 2'd2;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    wait_ready();
    htrans = 2'd0;
    hwdata = wd;
  endtask

  task automatic finish_xfer();
    wait_ready();
  endtask

  initial begin
    rst = 1'b1; hsel = 1'b0; sel_b = 1'b0; haddr = '0; htrans = 2'd0;
    hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    hsel = 1'b1;

    // Selected but IDLE/BUSY: zero-wait OKAY, no data.
    for (int i = 0; i < 6; i++) begin
      htrans = (i % 2 == 0) ? 2'd0 : 2'd1;
      @(posedge clk);
      #1;
    end
    htrans = 2'd0;

    // Word write then read.
    issue(1, 1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, "wr100", 32'h0, 2'd0);
    issue(1, 0, 3'd2, 32'h0000_0100, 32'h0,         "rd100", 32'hDEAD_BEEF, 2'd0);
    finish_xfer();

    // Byte lanes 0 and 3 with junk in the other lanes of HWDATA.
    issue(1, 1, 3'd2, 32'h0000_0200, 32'hAABB_CCDD, "wr200", 32'h0, 2'd0);
    issue(1, 1, 3'd0, 32'h0000_0200, 32'h9988_7711, "wb200", 32'h0, 2'd0);
    issue(1, 1, 3'd0, 32'h0000_0203, 32'h4477_6655, "wb203", 32'h0, 2'd0);
    issue(1, 0, 3'd2, 32'h0000_0200, 32'h0,         "rd200", 32'h44BB_CC11, 2'd0);
    finish_xfer();

    // Misaligned/oversized transfers error out and leave memory alone.
    issue(1, 1, 3'd2, 32'h0000_0300, 32'hCAFE_F00D, "wr300",   32'h0, 2'd0);
    issue(1, 1, 3'd1, 32'h0000_0301, 32'h1234_1234, "errh301", 32'h0, 2'd1);
    issue(1, 0, 3'd2, 32'h0000_0300, 32'h0,         "rd300a",  32'hCAFE_F00D, 2'd0);
    issue(1, 1, 3'd1, 32'h0000_0302, 32'hBEEF_1234, "wh302",   32'h0, 2'd0);
    issue(1, 0, 3'd2, 32'h0000_0302, 32'h0,         "errw302", 32'h0, 2'd1);
    issue(1, 0, 3'd3, 32'h0000_0300, 32'h0,         "errsz3",  32'h0, 2'd1);
    issue(1, 0, 3'd2, 32'h0000_0300, 32'h0,         "rd300b",  32'hBEEF_F00D, 2'd0);
    finish_xfer();

    // Back-to-back write/read, then aliased and out-of-range address bits.
    issue(1, 1, 3'd2, 32'h0000_0040, 32'h1234_5678, "wr40",   32'h0, 2'd0);
    issue(1, 0, 3'd2, 32'h0000_0040, 32'h0,         "rd40",   32'h1234_5678, 2'd0);
    issue(1, 0, 3'd2, 32'hF010_1040, 32'h0,         "rdalias", 32'h1234_5678, 2'd0);
    finish_xfer();

    // Reset during the wait of a write aborts it.
    issue(1, 1, 3'd2, 32'h0000_0500, 32'h1357_9BDF, "wr500", 32'h0, 2'd0);
    finish_xfer();
    issue(0, 1, 3'd2, 32'h0000_0500, 32'hFFFF_FFFF, "abort", 32'h0, 2'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1, 0, 3'd2, 32'h0000_0500, 32'h0, "rd500", 32'h1357_9BDF, 2'd0);
    finish_xfer();

    // Fixed-delay instance: exactly three waits each.
    sel_b = 1'b1;
    wmin  = 3;
    wmax  = 3;
    issue(1, 1, 3'd2, 32'h0000_0010, 32'h55AA_55AA, "b_wr10", 32'h0, 2'd0);
    issue(1, 0, 3'd2, 32'h0000_0010, 32'h0,         "b_rd10", 32'h55AA_55AA, 2'd0);
    issue(1, 1, 3'd0, 32'h0000_0013, 32'h0100_0000, "b_wb13", 32'h0, 2'd0);
    issue(1, 0, 3'd2, 32'h0000_0010, 32'h0,         "b_rd10b", 32'h01AA_55AA, 2'd0);
    finish_xfer();

    sel_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    summary_and_finish();
  end

  initial begin
    #200000;
    n_cmp++; n_mis++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    summary_and_finish();
  end

endmodule
